// File: rtl/mux_tree_pipe_if.sv
// Bus bundle for mux_tree_pipe: request side (valid, hold, select, channels)
// and result side (valid, selected data, optional parity).
// MUX_TREE_PAR_EN adds the out_par result bit.
interface mux_tree_pipe_if #(
   parameter int DATA_W = 64,
   parameter int SEL_W  = 5
);
   localparam int N = 1 << SEL_W;

   logic                in_valid;
   logic                hold;
   logic [SEL_W-1:0]    select;
   logic [N*DATA_W-1:0] mux_in;
   logic                out_valid;
   logic [DATA_W-1:0]   out;
`ifdef MUX_TREE_PAR_EN
   logic                out_par;

   modport master (output in_valid, hold, select, mux_in,
                   input  out_valid, out, out_par);
   modport slave  (input  in_valid, hold, select, mux_in,
                   output out_valid, out, out_par);
`else
   modport master (output in_valid, hold, select, mux_in,
                   input  out_valid, out);
   modport slave  (input  in_valid, hold, select, mux_in,
                   output out_valid, out);
`endif
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 multiplexer tree (N = 2**SEL_W channels of DATA_W bits).
// Each stage resolves two select bits (the last stage one bit when SEL_W is
// odd) and registers the reduced channel vector, the remaining select bits
// and a valid bit. hold freezes every stage. out/out_valid come straight
// from the final stage register.
// Optional feature macro: MUX_TREE_PAR_EN (registered XOR parity on out_par).
module mux_tree_pipe #(
   parameter int DATA_W = 64,
   parameter int SEL_W  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   mux_tree_pipe_if.slave    bus
);
   localparam int L = (SEL_W + 1) / 2;

   for (genvar s = 0; s < L; s++) begin : g_st
      localparam int SI  = SEL_W - 2 * s;       // select bits arriving here
      localparam int NLV = (SI >= 2) ? 2 : 1;   // 2:1 levels in this stage
      localparam int SO  = SI - NLV;            // select bits passed on
      localparam int SW  = (SO > 0) ? SO : 1;
      localparam int CI  = 1 << SI;             // channels arriving
      localparam int CH  = CI / 2;              // channels after first level
      localparam int CO  = 1 << SO;             // channels leaving

      logic [CI*DATA_W-1:0] din;
      logic [SI-1:0]        sin;
      logic                 vin;
      logic [CH*DATA_W-1:0] half;
      logic [CO*DATA_W-1:0] dat_d;
      logic [CO*DATA_W-1:0] dat_q;
      logic [SW-1:0]        sel_q;
      logic                 vld_q;

      if (s == 0) begin : g_src
         assign din = bus.mux_in;
         assign sin = bus.select;
         assign vin = bus.in_valid;
      end else begin : g_link
         assign din = g_st[s-1].dat_q;
         assign sin = g_st[s-1].sel_q;
         assign vin = g_st[s-1].vld_q;
      end

      // First 2:1 level of the pair, steered by the lowest remaining select bit
      always_comb begin
         half = '0;
         for (int c = 0; c < CH; c++) begin
            half[c*DATA_W +: DATA_W] = sin[0] ? din[(2*c+1)*DATA_W +: DATA_W]
                                              : din[(2*c)*DATA_W +: DATA_W];
         end
      end

      if (NLV == 2) begin : g_two
         // Second 2:1 level of the pair, steered by the next select bit
         always_comb begin
            dat_d = '0;
            for (int c = 0; c < CO; c++) begin
               dat_d[c*DATA_W +: DATA_W] = sin[1] ? half[(2*c+1)*DATA_W +: DATA_W]
                                                  : half[(2*c)*DATA_W +: DATA_W];
            end
         end
      end else begin : g_one
         assign dat_d = half;
      end

      if (SO > 0) begin : g_sel
         // Carry the select bits still needed downstream; load only on a new transaction
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)             sel_q <= '0;
            else if (!bus.hold && vin) sel_q <= sin[SI-1:NLV];
         end
      end else begin : g_nosel
         logic unused_sel;
         assign sel_q      = '0;
         assign unused_sel = ^sel_q;
      end

      // Stage data register: captures the reduced vector, keeps it when idle or held
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)             dat_q <= '0;
         else if (!bus.hold && vin) dat_q <= dat_d;
      end

      // Stage valid bit: follows upstream valid unless the pipeline is held
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)      vld_q <= 1'b0;
         else if (!bus.hold) vld_q <= vin;
      end
   end

   assign bus.out       = g_st[L-1].dat_q;
   assign bus.out_valid = g_st[L-1].vld_q;

`ifdef MUX_TREE_PAR_EN
   logic par_q;

   // Parity of the value loaded into out, registered alongside it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         par_q <= 1'b0;
      else if (!bus.hold && g_st[L-1].vin) par_q <= ^g_st[L-1].dat_d;
   end

   assign bus.out_par = par_q;
`endif
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: a DATA_W=8/SEL_W=5 instance checked
// against a transaction-queue reference model, plus a DATA_W=4/SEL_W=3 instance
// for the odd-depth case. Parity checks are active with MUX_TREE_PAR_EN.
module tb_mux_tree_pipe;
   localparam int DW = 8;
   localparam int SW = 5;
   localparam int N  = 32;
   localparam int L  = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   mux_tree_pipe_if #(.DATA_W(DW), .SEL_W(SW)) b ();
   mux_tree_pipe #(.DATA_W(DW), .SEL_W(SW)) dut (
      .clk(clk), .reset_n(reset_n), .bus(b));

   mux_tree_pipe_if #(.DATA_W(4), .SEL_W(3)) b2 ();
   mux_tree_pipe #(.DATA_W(4), .SEL_W(3)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(b2));

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int         left;
      logic [7:0] val;
   } tx_t;

   tx_t        q[$];
   logic [7:0] exp_out;
   logic       exp_vld;

   task automatic model_reset();
      q.delete();
      exp_out = '0;
      exp_vld = 1'b0;
   endtask

   // Present one cycle of inputs, advance the reference model at the edge.
   // A transaction needs L un-held edges (including the capture edge) to appear.
   task automatic drive_edge(input logic v, input logic h, input logic [4:0] s);
      tx_t t;
      b.in_valid = v;
      b.hold     = h;
      b.select   = s;
      @(posedge clk);
      if (!h) begin
         foreach (q[k]) q[k].left = q[k].left - 1;
         if (v) begin
            t.left = L - 1;
            t.val  = b.mux_in[int'(s)*8 +: 8];
            q.push_back(t);
         end
         exp_vld = 1'b0;
         if (q.size() > 0 && q[0].left == 0) begin
            exp_vld = 1'b1;
            exp_out = q[0].val;
            void'(q.pop_front());
         end
      end
      #1;
   endtask

   task automatic set_ramp();
      for (int i = 0; i < N; i++) b.mux_in[i*8 +: 8] = 8'(i + 8'h40);
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (b.out !== 8'h00 || b.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_init: out=%h vld=%b, want 00/0", b.out, b.out_valid);
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset();
      set_ramp();
      for (int e = 0; e < 6; e++) begin
         drive_edge(1'b1, 1'b0, 5'($urandom_range(0, N-1)));
         n_cmp++;
         if (b.out !== exp_out || b.out_valid !== exp_vld) begin
            n_err++;
            $display("FAIL reset_fill[%0d]: out=%h vld=%b, want %h/%b",
                     e, b.out, b.out_valid, exp_out, exp_vld);
         end
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (b.out !== 8'h00 || b.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_async: out=%h vld=%b, want 00/0", b.out, b.out_valid);
      end
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int e = 0; e < 6; e++) begin
         drive_edge(1'b0, 1'b0, 5'd0);
         n_cmp++;
         if (b.out !== 8'h00 || b.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stale[%0d]: out=%h vld=%b, want 00/0",
                     e, b.out, b.out_valid);
         end
      end
   endtask

   task automatic test_sweep();
      set_ramp();
      for (int e = 1; e <= 35; e++) begin
         drive_edge(e <= 32, 1'b0, 5'((e - 1) % 32));
         n_cmp++;
         if (b.out !== exp_out || b.out_valid !== exp_vld) begin
            n_err++;
            $display("FAIL sweep_model[%0d]: out=%h vld=%b, want %h/%b",
                     e, b.out, b.out_valid, exp_out, exp_vld);
         end
         if (e >= 3 && e <= 34) begin
            n_cmp++;
            if (b.out !== 8'(8'h40 + e - 3) || b.out_valid !== 1'b1) begin
               n_err++;
               $display("FAIL sweep_seq[%0d]: out=%h vld=%b, want %h/1",
                        e, b.out, b.out_valid, 8'(8'h40 + e - 3));
            end
         end
      end
   endtask

   task automatic test_onehot();
      int n_ff = 0;
      int n_v  = 0;
      for (int e = 0; e < 1024 + L; e++) begin
         b.mux_in = '0;
         if (e < 1024) b.mux_in[(e % 32)*8 +: 8] = 8'hFF;
         drive_edge(e < 1024, 1'b0, 5'(e / 32));
         n_cmp++;
         if (b.out !== exp_out || b.out_valid !== exp_vld) begin
            n_err++;
            $display("FAIL onehot[%0d]: out=%h vld=%b, want %h/%b",
                     e, b.out, b.out_valid, exp_out, exp_vld);
         end
         if (b.out_valid === 1'b1) begin
            n_v++;
            if (b.out === 8'hFF) n_ff++;
         end
      end
      n_cmp++;
      if (n_ff != 32 || n_v != 1024) begin
         n_err++;
         $display("FAIL onehot_count: ff=%0d valid=%0d, want 32/1024", n_ff, n_v);
      end
   endtask

   task automatic test_hold();
      logic [2:0] tbl [11];
      logic       want_v [11];
      logic [4:0] sels [11];
      tbl    = '{3'b010, 3'b011, 3'b011, 3'b000, 3'b000, 3'b011, 3'b001,
                 3'b000, 3'b000, 3'b000, 3'b000};
      want_v = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
      sels   = '{5'd7, 5'd3, 5'd9, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      for (int i = 0; i < N; i++) b.mux_in[i*8 +: 8] = 8'($urandom_range(0, 255));
      b.mux_in[7*8 +: 8] = 8'hA5;
      for (int e = 0; e < 11; e++) begin
         // tbl bit1 = in_valid, bit0 = hold
         drive_edge(tbl[e][1], tbl[e][0], sels[e]);
         n_cmp++;
         if (b.out_valid !== want_v[e] || b.out !== exp_out) begin
            n_err++;
            $display("FAIL hold[%0d]: out=%h vld=%b, want %h/%b",
                     e + 1, b.out, b.out_valid, exp_out, want_v[e]);
         end
         if (e >= 4) begin
            n_cmp++;
            if (b.out !== 8'hA5) begin
               n_err++;
               $display("FAIL hold_data[%0d]: out=%h, want a5", e + 1, b.out);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int e = 0; e < 400; e++) begin
         for (int i = 0; i < N; i++) b.mux_in[i*8 +: 8] = 8'($urandom_range(0, 255));
         drive_edge(($urandom % 4) != 0, ($urandom % 5) == 0,
                    5'($urandom_range(0, N-1)));
         n_cmp++;
         if (b.out !== exp_out || b.out_valid !== exp_vld) begin
            n_err++;
            $display("FAIL random[%0d]: out=%h vld=%b, want %h/%b",
                     e, b.out, b.out_valid, exp_out, exp_vld);
         end
`ifdef MUX_TREE_PAR_EN
         n_cmp++;
         if (b.out_par !== ^exp_out) begin
            n_err++;
            $display("FAIL random_par[%0d]: par=%b, want %b", e, b.out_par, ^exp_out);
         end
`endif
      end
   endtask

   task automatic test_odd();
      logic [3:0] vals [2];
      logic [3:0] want;
      logic [2:0] sel;
      vals = '{4'hB, 4'h9};
      for (int k = 0; k < 2; k++) begin
         b2.mux_in = 32'($urandom);
         b2.mux_in[5*4 +: 4] = vals[k];
         b2.select   = 3'd5;
         b2.in_valid = 1'b1;
         @(posedge clk);
         #1 b2.in_valid = 1'b0;
         n_cmp++;
         if (b2.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL odd_early[%0d]: vld=%b, want 0", k, b2.out_valid);
         end
         @(posedge clk);
         #1;
         n_cmp++;
         if (b2.out_valid !== 1'b1 || b2.out !== vals[k]) begin
            n_err++;
            $display("FAIL odd_data[%0d]: out=%h vld=%b, want %h/1",
                     k, b2.out, b2.out_valid, vals[k]);
         end
`ifdef MUX_TREE_PAR_EN
         n_cmp++;
         if (b2.out_par !== (k == 0 ? 1'b1 : 1'b0)) begin
            n_err++;
            $display("FAIL odd_par[%0d]: par=%b, want %b", k, b2.out_par, k == 0);
         end
`endif
         @(posedge clk);
         #1;
         n_cmp++;
         if (b2.out_valid !== 1'b0 || b2.out !== vals[k]) begin
            n_err++;
            $display("FAIL odd_after[%0d]: out=%h vld=%b, want %h/0",
                     k, b2.out, b2.out_valid, vals[k]);
         end
      end
      for (int t = 0; t < 16; t++) begin
         b2.mux_in   = 32'($urandom);
         sel         = 3'($urandom_range(0, 7));
         want        = b2.mux_in[int'(sel)*4 +: 4];
         b2.select   = sel;
         b2.in_valid = 1'b1;
         @(posedge clk);
         #1 b2.in_valid = 1'b0;
         @(posedge clk);
         #1;
         n_cmp++;
         if (b2.out_valid !== 1'b1 || b2.out !== want) begin
            n_err++;
            $display("FAIL odd_rand[%0d]: out=%h vld=%b, want %h/1",
                     t, b2.out, b2.out_valid, want);
         end
      end
   endtask

   initial begin
      b.in_valid  = 1'b0;
      b.hold      = 1'b0;
      b.select    = '0;
      b.mux_in    = '0;
      b2.in_valid = 1'b0;
      b2.hold     = 1'b0;
      b2.select   = '0;
      b2.mux_in   = '0;
      model_reset();
      test_reset();
      test_sweep();
      test_onehot();
      test_hold();
      test_random();
      test_odd();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N-to-1 multi-bit multiplexer tree. Selects one `DATA_W`-bit channel out of `2**SEL_W` channels. A pipeline register sits after every two 2:1 levels, so the tree runs at register-file clock rates for wide, deep selections. It carries a valid bit and a pipeline-wide hold, and is the register-file read-port selector for the datapath.

## Interface
- `DATA_W`, default 64: width of each channel and of `out`; legal 1..128.
- `SEL_W`, default 5: select width; channel count N = 2**SEL_W; legal 1..8.
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `select` and `mux_in` are valid this cycle.
- `hold`  in  1: freeze the whole pipeline this cycle.
- `select`  in  SEL_W: channel index, unsigned.
- `mux_in`  in  N*DATA_W: flattened channels; channel i = `mux_in[i*DATA_W +: DATA_W]`.
- `out_valid`  out  1: `out` carries a new result this cycle.
- `out`  out  DATA_W: selected channel.
- `out_par`  out  1: present only with `MUX_TREE_PAR_EN`.

## Operation
- The tree has SEL_W levels of 2:1 selection. Level k uses `select[k]`: level 0 (LSB) acts on the input channels, the last level (MSB) produces the result.
- Levels are grouped in pairs: {0,1}, {2,3}, …. Each group ends in a stage register. With odd SEL_W, the last group is one level.
- Number of stages L = ceil(SEL_W/2).
- Each stage register holds:
  - the partially reduced channel vector (N/4**s entries after stage s; N/2**SEL_W = 1 at the final stage);
  - the unused upper select bits;
  - a valid bit.
- Stage register loads:
  - `hold`=0: valid bit loads its upstream valid.
  - `hold`=0 and upstream valid=1: data and select loads.
  - Otherwise: data and select keep their previous value.
- `hold`=1: every stage register keeps its value. `in_valid`, `select` and `mux_in` are ignored that cycle, so a transaction presented during hold is dropped.
- `out` and `out_valid` are the final stage register outputs directly; there is no combinational path from inputs to outputs.
- `out` keeps the last valid result while `out_valid`=0.
- Selection is exact: `out` = channel `select`, with no wrap, saturation or sign handling. Every index 0..N-1 is legal.

## Timing
- Reset (`reset_n`=0, asynchronous): all stage valid bits, data, select bits, `out`, `out_valid` and `out_par` go to 0 immediately.
- Deasserting reset takes effect at the next rising edge. The first capture happens on the first edge with `reset_n`=1.
- Latency: a transaction accepted at edge t (`in_valid`=1, `hold`=0) appears with `out_valid`=1 after edge t+L-1, i.e. L edges including the capture edge, provided there is no hold.
- Each cycle of `hold`=1 adds exactly one cycle of latency to every in-flight transaction.
- Throughput is one transaction per cycle. Back-to-back transactions with different selects come out in order without interference.
- `out_valid` is high for exactly one cycle per transaction, unless `hold` keeps it asserted. During hold, `out_valid` and `out` stay stable.
- Reset during operation flushes all in-flight transactions; none are output afterwards.
- `in_valid`=1 together with `hold`=1: the transaction is lost, not queued.

## Configuration
- `MUX_TREE_PAR_EN` defined:
  - `out_par` exists and equals the XOR-reduction of the value loaded into `out`.
  - It is registered in the same final stage, resets to 0, and holds with `out`.
- `MUX_TREE_PAR_EN` undefined: `out_par` port and its logic are absent. Latency and every other behaviour are unchanged.

## Test plan
All scenarios use `DATA_W`=8, `SEL_W`=5 (N=32, L=3) unless stated.
- Reset: `reset_n`=0 mid-stream with 3 transactions in flight → `out`=0x00 and `out_valid`=0 with no clock edge. After release, no stale results appear.
- Sweep: channel i = 8'(i+0x40); `select`=0..31 back-to-back with `in_valid`=1 → edges 3..34 show `out`=0x40..0x5F in order, `out_valid` high continuously.
- One-hot walk:
  - for each `select` s, drive `mux_in` with only channel j = 0xFF, for all j;
  - required: `out`=0xFF iff j==s, else 0x00, for all 1024 combinations.
- Hold:
  - accept `select`=7 (channel 7 = 0xA5), then raise `hold` for 2 cycles at the second edge;
  - required: result appears after 5 edges and stays stable during hold;
  - `in_valid` pulses during hold produce no output.
- Odd depth/parity:
  - `SEL_W`=3, `DATA_W`=4 (L=2), channel 5 = 0xB, `select`=5 → `out`=0xB after 2 edges;
  - with `MUX_TREE_PAR_EN`: `out_par`=1; 0x9 gives `out_par`=0.
